// File: rtl/icache_pkg.sv
// icache_pkg: controller state encoding and address-field width helpers for icache_nway.
package icache_pkg;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FLUSH} state_t;

    function automatic int off_w(input int line_bits);
        return $clog2(line_bits / 8);
    endfunction

    function automatic int idx_w(input int log_sets);
        return log_sets;
    endfunction

    function automatic int tag_w(input int addr_w, input int line_bits, input int log_sets);
        return addr_w - off_w(line_bits) - idx_w(log_sets);
    endfunction

endpackage

// File: rtl/icache_way.sv
// icache_way: one way of the cache -- data, tag and valid storage with a registered read port.
module icache_way #(
    parameter int LOG_SETS  = 7,
    parameter int TAG_W     = 51,
    parameter int LINE_BITS = 512
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd_en,
    input  logic [LOG_SETS-1:0]  rd_idx,
    input  logic                 we,
    input  logic [LOG_SETS-1:0]  wr_idx,
    input  logic [TAG_W-1:0]     wr_tag,
    input  logic [LINE_BITS-1:0] wr_data,
    input  logic                 clear,
    output logic                 rd_valid,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [LINE_BITS-1:0] rd_data
);
    localparam int SETS = 1 << LOG_SETS;

    logic [SETS-1:0]      valid;
    logic [TAG_W-1:0]     tags [SETS];
    logic [LINE_BITS-1:0] data [SETS];

    // Valid bits live in flops so reset and flush can clear them in a single cycle.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            valid    <= '0;
            rd_valid <= 1'b0;
        end else begin
            valid    <= clear ? '0 : we ? (valid | (SETS'(1) << wr_idx)) : valid;
            rd_valid <= rd_en ? valid[rd_idx] : rd_valid;
        end

    always_ff @(posedge clk) begin
        if (we) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_tag  <= tags[rd_idx];
            rd_data <= data[rd_idx];
        end
    end

endmodule

// File: rtl/icache_nway.sv
// icache_nway: N-way set-associative instruction cache with round-robin replacement and flush.
// Optional ICACHE_STATS_EN adds saturating 32-bit hit_count / miss_count outputs.
module icache_nway
    import icache_pkg::*;
#(
    parameter int WAYS      = 4,
    parameter int LOG_SETS  = 7,
    parameter int LINE_BITS = 512,
    parameter int ADDR_W    = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [ADDR_W-1:0]    addr,
    input  logic                 flush,
    output logic [LINE_BITS-1:0] rdata,
    output logic                 done,
    output logic                 irequest,
    input  logic                 ireqack,
    output logic [ADDR_W-1:0]    iaddr,
    input  logic [LINE_BITS-1:0] idata,
    input  logic                 idone
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
`endif
);
    localparam int OFF_W = off_w(LINE_BITS);
    localparam int IDX_W = idx_w(LOG_SETS);
    localparam int TAG_W = tag_w(ADDR_W, LINE_BITS, LOG_SETS);
    localparam int SETS  = 1 << IDX_W;
    localparam int WAY_W = WAYS > 1 ? $clog2(WAYS) : 1;

    state_t state, next;

    logic [ADDR_W-1:0]    addr_q;
    logic [IDX_W-1:0]     idx_q;
    logic [TAG_W-1:0]     tag_q;
    logic                 flush_pend;
    logic                 accept, fill, clear, lookup_hit, lookup_miss, hit;
    logic [WAYS-1:0]      way_valid, way_we, hits;
    logic [TAG_W-1:0]     way_tag [WAYS];
    logic [LINE_BITS-1:0] way_data [WAYS];
    logic [LINE_BITS-1:0] hit_data;
    logic [WAY_W-1:0]     rr [SETS];
    logic [WAY_W-1:0]     victim, victim_q;

    assign idx_q = addr_q[OFF_W +: IDX_W];
    assign tag_q = addr_q[ADDR_W-1 -: TAG_W];
    assign iaddr = addr_q;
    assign hit   = |hits;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign hits[w]   = way_valid[w] && way_tag[w] == tag_q;
        assign way_we[w] = fill && victim_q == WAY_W'(w);
        icache_way #(
            .LOG_SETS  (IDX_W),
            .TAG_W     (TAG_W),
            .LINE_BITS (LINE_BITS)
        ) u_way (
            .clk      (clk),
            .reset    (reset),
            .rd_en    (state == IDLE),
            .rd_idx   (addr[OFF_W +: IDX_W]),
            .we       (way_we[w]),
            .wr_idx   (idx_q),
            .wr_tag   (tag_q),
            .wr_data  (idata),
            .clear    (clear),
            .rd_valid (way_valid[w]),
            .rd_tag   (way_tag[w]),
            .rd_data  (way_data[w])
        );
    end

    always_comb begin
        hit_data = '0;
        for (int w = 0; w < WAYS; w++)
            hit_data = hits[w] ? (hit_data | way_data[w]) : hit_data;
    end

    // Lowest-numbered invalid way wins; otherwise fall back to the set's pointer.
    always_comb begin
        victim = rr[idx_q];
        for (int w = WAYS - 1; w >= 0; w--)
            victim = way_valid[w] ? victim : WAY_W'(w);
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= next;

    always_comb begin
        next = state;
        case (state)
            IDLE:      next = (flush || flush_pend) ? FLUSH : enable ? LOOKUP : IDLE;
            LOOKUP:    next = hit ? IDLE : MISS_REQ;
            MISS_REQ:  next = idone ? IDLE : ireqack ? MISS_WAIT : MISS_REQ;
            MISS_WAIT: next = idone ? IDLE : MISS_WAIT;
            FLUSH:     next = IDLE;
            default:   next = IDLE;
        endcase
    end

    always_comb begin
        accept      = state == IDLE && enable && !flush && !flush_pend;
        irequest    = state == MISS_REQ;
        fill        = (state == MISS_REQ || state == MISS_WAIT) && idone;
        clear       = state == FLUSH;
        lookup_hit  = state == LOOKUP && hit;
        lookup_miss = state == LOOKUP && !hit;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            addr_q     <= '0;
            victim_q   <= '0;
            done       <= 1'b0;
            rdata      <= '0;
            flush_pend <= 1'b0;
            for (int s = 0; s < SETS; s++) rr[s] <= '0;
        end else begin
            addr_q     <= accept ? {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : addr_q;
            victim_q   <= state == LOOKUP ? victim : victim_q;
            done       <= lookup_hit || fill;
            rdata      <= lookup_hit ? hit_data : fill ? idata : rdata;
            flush_pend <= state == FLUSH ? 1'b0 : flush_pend || (flush && state != IDLE);
            if (fill)
                rr[idx_q] <= rr[idx_q] == WAY_W'(WAYS - 1) ? '0 : rr[idx_q] + 1'b1;
        end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            hit_count  <= (lookup_hit && ~&hit_count) ? hit_count + 32'd1 : hit_count;
            miss_count <= (lookup_miss && ~&miss_count) ? miss_count + 32'd1 : miss_count;
        end
`endif

endmodule

// File: tb/tb_icache_nway.sv
// tb_icache_nway: directed plus randomized checks of icache_nway against a set/way reference model.
module tb_icache_nway;
    localparam int WAYS = 4;
    localparam int SETS = 128;

    logic         clk = 0, reset = 1, enable = 0, flush = 0, ireqack = 0, idone = 0;
    logic [63:0]  addr = '0;
    logic [511:0] idata = '0;
    logic [511:0] rdata;
    logic         done, irequest;
    logic [63:0]  iaddr;
`ifdef ICACHE_STATS_EN
    logic [31:0]  hit_count, miss_count;
`endif

    int tests = 0, fails = 0;

    bit           mv  [SETS][WAYS];
    logic [50:0]  mt  [SETS][WAYS];
    logic [511:0] md  [SETS][WAYS];
    int           mrr [SETS];
    int           mh = 0, mm = 0;

    icache_nway dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .addr      (addr),
        .flush     (flush),
        .rdata     (rdata),
        .done      (done),
        .irequest  (irequest),
        .ireqack   (ireqack),
        .iaddr     (iaddr),
        .idata     (idata),
        .idone     (idone)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rnd_line();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_flush();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) mv[s][w] = 0;
    endtask

    task automatic model_reset();
        model_flush();
        for (int s = 0; s < SETS; s++) mrr[s] = 0;
        mh = 0;
        mm = 0;
    endtask

    task automatic access(input logic [63:0] a, input int ack_delay, input bit same, input bit flush_w);
        logic [63:0]  la;
        logic [50:0]  t;
        logic [511:0] d;
        int s, hw, v;
        la = {a[63:6], 6'b0};
        t  = a[63:13];
        s  = int'(a[12:6]);
        d  = rnd_line();
        hw = -1;
        for (int w = 0; w < WAYS; w++) if (mv[s][w] && mt[s][w] == t) hw = w;
        enable = 1;
        addr = a;
        tick();
        enable = 0;
        addr = {$urandom, $urandom};
        tick();
        if (hw >= 0) begin
            mh++;
            check("hit_done", 512'(done), 512'(1));
            check("hit_rdata", rdata, md[s][hw]);
            check("hit_noreq", 512'(irequest), 512'(0));
        end else begin
            mm++;
            check("miss_req", 512'(irequest), 512'(1));
            check("miss_iaddr", 512'(iaddr), 512'(la));
            check("miss_nodone", 512'(done), 512'(0));
            repeat (ack_delay) tick();
            if (ack_delay > 0) check("req_hold", 512'({irequest, iaddr}), 512'({1'b1, la}));
            ireqack = 1;
            if (same) begin
                idone = 1;
                idata = d;
            end
            tick();
            ireqack = 0;
            if (!same) begin
                check("req_drop", 512'(irequest), 512'(0));
                flush = flush_w;
                tick();
                flush = 0;
                idone = 1;
                idata = d;
                tick();
            end
            idone = 0;
            idata = rnd_line();
            check("fill_done", 512'(done), 512'(1));
            check("fill_rdata", rdata, d);
            v = -1;
            for (int w = 0; w < WAYS; w++) if (!mv[s][w] && v < 0) v = w;
            if (v < 0) v = mrr[s];
            mv[s][v] = 1;
            mt[s][v] = t;
            md[s][v] = d;
            mrr[s] = (mrr[s] + 1) % WAYS;
            if (flush_w) model_flush();
        end
        tick();
        check("done_pulse", 512'(done), 512'(0));
        tick();
        tick();
    endtask

    task automatic idle_flush();
        flush = 1;
        tick();
        flush = 0;
        tick();
        tick();
        model_flush();
    endtask

    initial begin
        model_reset();
        tick();
        tick();
        check("rst_done", 512'(done), 512'(0));
        check("rst_req", 512'(irequest), 512'(0));
        check("rst_iaddr", 512'(iaddr), 512'(0));
        check("rst_rdata", rdata, 512'(0));
        reset = 0;
        tick();

        access(64'h1040, 1, 0, 0);
        access(64'h107F, 0, 0, 0);

        for (int k = 0; k < 5; k++) access(64'h40 + (64'(k) << 13), k % 3, k == 2, 0);
        for (int k = 1; k < 5; k++) access(64'h40 + (64'(k) << 13) + 64'(k), 0, 0, 0);
        access(64'h40, 0, 0, 0);

        access(64'h30C0, 1, 0, 1);
        access(64'h30C0, 0, 0, 0);

        access(64'h1040, 0, 0, 0);
        flush = 1;
        enable = 1;
        addr = 64'h1040;
        tick();
        flush = 0;
        enable = 0;
        tick();
        check("flush_prio_done", 512'(done), 512'(0));
        check("flush_prio_req", 512'(irequest), 512'(0));
        tick();
        model_flush();
        access(64'h1040, 2, 0, 0);

        idone = 1;
        ireqack = 1;
        idata = rnd_line();
        tick();
        idone = 0;
        ireqack = 0;
        check("idle_idone", 512'(done), 512'(0));
        tick();

        enable = 1;
        addr = 64'h2080;
        tick();
        enable = 0;
        tick();
        check("rmm_req", 512'(irequest), 512'(1));
        ireqack = 1;
        tick();
        ireqack = 0;
        reset = 1;
        tick();
        check("rmm_req_off", 512'(irequest), 512'(0));
        check("rmm_iaddr", 512'(iaddr), 512'(0));
        check("rmm_rdata", rdata, 512'(0));
        reset = 0;
        idone = 1;
        idata = rnd_line();
        tick();
        idone = 0;
        check("rmm_stray", 512'(done), 512'(0));
        tick();
        model_reset();

        access(64'h2080, 0, 0, 0);
        access(64'h4080, 1, 1, 0);
        access(64'h60C0, 0, 0, 0);
        access(64'h2080, 0, 0, 0);
        access(64'h4090, 0, 0, 0);
`ifdef ICACHE_STATS_EN
        check("stats_miss", 512'(miss_count), 512'(3));
        check("stats_hit", 512'(hit_count), 512'(2));
`endif

        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 19) == 0) idle_flush();
            else begin
                logic [63:0] a;
                bit sm;
                a = (64'($urandom_range(0, 5)) << 13) | (64'($urandom_range(0, 3)) << 6) | 64'($urandom_range(0, 63));
                sm = $urandom_range(0, 1) == 1;
                access(a, $urandom_range(0, 3), sm, !sm && $urandom_range(0, 9) == 0);
            end
        end
`ifdef ICACHE_STATS_EN
        check("stats_miss_end", 512'(miss_count), 512'(mm));
        check("stats_hit_end", 512'(hit_count), 512'(mh));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
